matrix_op_sequencer: RTL
========================

# matrix_op_sequencer

Sequences one complete matrix instruction onto the MatrixALU register bus. The block sits between the execution engine and the ALU: it accepts an opcode plus two 256-bit operands over a valid/ready handshake, writes the operands, triggers the operation, and reads back the result. It then returns the 256-bit result over a second valid/ready handshake. It is the only master of the ALU bus.

## Interface
- `TIMEOUT_UNUSED` – none; the block has no parameters. Opcodes are fixed: 0 MUL, 1 ADD, 2 SUB, 3 TRANSPOSE, 4 SCALE, 5 SCALEIMM.
- `Clk  in  1`  single clock, rising edge.
- `nReset  in  1`  synchronous, active-low reset.
- `instValid  in  1`  an instruction is offered.
- `instReady  out  1`  the sequencer can accept an instruction.
- `instOp  in  4`  opcode.
- `instSrc1  in  256`  first operand, 4x4 of 16-bit elements.
- `instSrc2  in  256`  second operand; carries the scalar for SCALE/SCALEIMM.
- `address  out  16`  ALU bus address.
- `nRead  out  1`  ALU bus read strobe, active-low.
- `nWrite  out  1`  ALU bus write strobe, active-low.
- `ExeDataOut  out  256`  ALU bus write data.
- `MatrixDataOut  in  256`  ALU bus read data, registered inside the ALU.
- `resValid  out  1`  result available.
- `resReady  in  1`  consumer accepts the result.
- `resData  out  256`  result matrix.
- `resErr  out  1`  the instruction had an illegal opcode; qualified by `resValid`.
- `opCount  out  16`  completed-instruction counter (see Configuration).
- `busyCycles  out  16`  non-IDLE cycle counter (see Configuration).

## Operation
- Bus address format is {4'h2, 4'h0, op, fn}, where fn: 0 = write src1, 1 = write src2, 2 = read result, 3 = execute.
- When the bus is idle: address = 16'h0000, nRead = 1, nWrite = 1, ExeDataOut holds its last value.
- Only one bus strobe is ever active per cycle. nRead and nWrite are never low together.
- On acceptance (instValid & instReady), instOp, instSrc1 and instSrc2 are latched. Inputs are don't-care afterwards.
- FSM states:
  - **IDLE:** instReady = 1. On accept, go to ERR if op > 5, else to WR1.
  - **WR1:** address fn = 0, nWrite = 0, ExeDataOut = src1. If op == TRANSPOSE go to EXEC, else go to WR2.
  - **WR2:** fn = 1, nWrite = 0, ExeDataOut = src2. Go to EXEC.
  - **EXEC:** fn = 3, both strobes high. Go to RDRES.
  - **RDRES:** fn = 2, nRead = 0. Go to CAPT.
  - **CAPT:** bus idle. Register resData ← MatrixDataOut, resErr ← 0. Go to DONE.
  - **ERR:** no bus activity. resData ← 0, resErr ← 1. Go to DONE.
  - **DONE:** resValid = 1. When resReady is high, go to IDLE.
- resData and resErr are stable for the whole time resValid is high.
- No new instruction is accepted until the DONE handshake completes. instReady is low in every state except IDLE.

## Timing
- Reset values: instReady = 0 during reset, then 1 on the first cycle after reset in IDLE; address = 0; nRead = 1; nWrite = 1; ExeDataOut = 0; resValid = 0; resData = 0; resErr = 0; opCount = 0; busyCycles = 0.
- Cycle 0 is the accept edge. For a two-operand op, the states are WR1@1, WR2@2, EXEC@3, RDRES@4, CAPT@5, and resValid is high at cycle 6.
  - TRANSPOSE: resValid high at cycle 5.
  - Illegal op: ERR@1, resValid high at cycle 2.
- Earliest next accept is the cycle after the resValid & resReady edge. Steady-state throughput is one instruction per 7 cycles when resReady is held high.
- nReset low at any edge forces IDLE and all reset values on the next cycle, even mid-operation. An in-flight instruction is dropped and no result is produced.
- resReady high outside DONE has no effect.

## Configuration
- `MATRIX_SEQ_PERF_EN` defined:
  - opCount increments by 1 on each DONE handshake with resErr = 0.
  - busyCycles increments on every cycle the FSM is not in IDLE.
  - Both counters saturate at 16'hFFFF and clear on reset.
- `MATRIX_SEQ_PERF_EN` undefined: opCount and busyCycles are tied to 0 and no counter logic is built.

## Test plan
- ADD with src1 all 16'h0001 and src2 all 16'h0002, resReady = 1: bus sequence is 0x2010 write, 0x2011 write, 0x2013, 0x2012 read. resValid is high at cycle 6 with resData all 16'h0003 and resErr = 0.
- TRANSPOSE with src1 element [r][c] = {r,c}: there is no write with fn = 1. resValid is high at cycle 5 with element [r][c] = {c,r}.
- instOp = 4'h7: no strobe goes low, address stays 0. resValid is high at cycle 2 with resErr = 1 and resData = 0. With the macro defined, opCount is unchanged.
- MUL, then resReady held low for 3 cycles: resData is stable, instReady = 0, and instValid held high is not accepted. Acceptance occurs one cycle after resReady rises.
- nReset pulsed low during EXEC: the next cycle has address = 0, nRead = nWrite = 1, resValid = 0 and IDLE. A following SUB (5 − 3 in every element) returns all 16'h0002.
- With MATRIX_SEQ_PERF_EN, two back-to-back ADDs with resReady = 1 give opCount = 2 and busyCycles = 12.

Source files
------------

// File: rtl/matrix_op_sequencer.sv
// rtl/matrix_op_sequencer.sv - sequences one matrix instruction onto the MatrixALU register bus
// Optional perf counters built when MATRIX_SEQ_PERF_EN is defined.
module matrix_op_sequencer (
    input  logic         Clk,
    input  logic         nReset,
    input  logic         instValid,
    output logic         instReady,
    input  logic [3:0]   instOp,
    input  logic [255:0] instSrc1,
    input  logic [255:0] instSrc2,
    output logic [15:0]  address,
    output logic         nRead,
    output logic         nWrite,
    output logic [255:0] ExeDataOut,
    input  logic [255:0] MatrixDataOut,
    output logic         resValid,
    input  logic         resReady,
    output logic [255:0] resData,
    output logic         resErr,
    output logic [15:0]  opCount,
    output logic [15:0]  busyCycles
);
    typedef enum logic [2:0] {
        S_IDLE, S_WR1, S_WR2, S_EXEC, S_RDRES, S_CAPT, S_ERR, S_DONE
    } state_t;

    localparam logic [3:0] FN_WR1  = 4'd0;
    localparam logic [3:0] FN_WR2  = 4'd1;
    localparam logic [3:0] FN_READ = 4'd2;
    localparam logic [3:0] FN_EXEC = 4'd3;
    localparam logic [3:0] OP_TRANSPOSE = 4'd3;
    localparam logic [3:0] OP_MAX       = 4'd5;

    state_t         state, state_next;
    logic [3:0]     op_q;
    logic [255:0]   src1_q, src2_q;
    logic [255:0]   exe_hold;
    logic [255:0]   res_data_q;
    logic           res_err_q;

    // Ready is suppressed while reset is asserted, even though the state is already IDLE.
    assign instReady = (state == S_IDLE) && nReset;
    assign resValid  = (state == S_DONE);
    assign resData   = res_data_q;
    assign resErr    = res_err_q;

    always_ff @(posedge Clk) begin
        if (!nReset) begin
            state      <= S_IDLE;
            op_q       <= '0;
            src1_q     <= '0;
            src2_q     <= '0;
            exe_hold   <= '0;
            res_data_q <= '0;
            res_err_q  <= 1'b0;
        end else begin
            state <= state_next;
            if (instValid && instReady) begin
                op_q   <= instOp;
                src1_q <= instSrc1;
                src2_q <= instSrc2;
            end
            case (state)
                S_WR1:  exe_hold <= src1_q;
                S_WR2:  exe_hold <= src2_q;
                S_CAPT: begin
                    res_data_q <= MatrixDataOut;
                    res_err_q  <= 1'b0;
                end
                S_ERR: begin
                    res_data_q <= '0;
                    res_err_q  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        address    = 16'h0000;
        nRead      = 1'b1;
        nWrite     = 1'b1;
        ExeDataOut = exe_hold;
        case (state)
            S_IDLE: begin
                if (instValid && nReset)
                    state_next = (instOp > OP_MAX) ? S_ERR : S_WR1;
            end
            S_WR1: begin
                address    = {8'h20, op_q, FN_WR1};
                nWrite     = 1'b0;
                ExeDataOut = src1_q;
                state_next = (op_q == OP_TRANSPOSE) ? S_EXEC : S_WR2;
            end
            S_WR2: begin
                address    = {8'h20, op_q, FN_WR2};
                nWrite     = 1'b0;
                ExeDataOut = src2_q;
                state_next = S_EXEC;
            end
            S_EXEC: begin
                address    = {8'h20, op_q, FN_EXEC};
                state_next = S_RDRES;
            end
            S_RDRES: begin
                address    = {8'h20, op_q, FN_READ};
                nRead      = 1'b0;
                state_next = S_CAPT;
            end
            S_CAPT:  state_next = S_DONE;
            S_ERR:   state_next = S_DONE;
            S_DONE: begin
                if (resReady)
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

`ifdef MATRIX_SEQ_PERF_EN
    logic [15:0] op_cnt, busy_cnt;

    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge Clk) begin
        if (!nReset) begin
            op_cnt   <= '0;
            busy_cnt <= '0;
        end else begin
            if (state == S_DONE && resReady && !res_err_q && op_cnt != 16'hFFFF)
                op_cnt <= op_cnt + 16'd1;
            if (state != S_IDLE && busy_cnt != 16'hFFFF)
                busy_cnt <= busy_cnt + 16'd1;
        end
    end

    assign opCount    = op_cnt;
    assign busyCycles = busy_cnt;
`else
    assign opCount    = 16'h0000;
    assign busyCycles = 16'h0000;
`endif

endmodule
